saturn_rstk_jump_unit: RTL and testbench
========================================

Name: saturn_rstk_jump_unit

Overview:
Parametrised next-generation PC / return-stack unit for the Saturn core. It owns the program counter, assembles multi-nibble jump offsets (relative sign-extended or absolute), and executes GOSUB-style pushes and RTN pops. It also performs the explicit RSTK=C and C=RSTK transfers on a circular return stack of configurable depth, with occupancy count and sticky overflow/underflow flags. It sits between the instruction decoder and the bus fetch unit and drives the fetch address.

Parameters:
ADDR_W, 20, width of PC and of each stack entry.
RSTK_DEPTH, 8, number of stack entries; must be a power of 2, at least 2.
MAX_JUMP_NIBS, 5, maximum offset length in nibbles; MAX_JUMP_NIBS*4 >= ADDR_W.
PTR_W, $clog2(RSTK_DEPTH), derived localparam.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_clk_en  in  1  global enable; no state changes when low (reset still acts)
i_inc_pc  in  1  PC <= PC+1
i_jump_start  in  1  begin jump; samples i_jump_len, i_jump_rel, i_jump_push
i_jump_len  in  3  offset length in nibbles, 1..MAX_JUMP_NIBS
i_jump_rel  in  1  1 = relative (base + sign-extended offset), 0 = absolute
i_jump_push  in  1  push return address (GOSUB)
i_nib_valid  in  1  i_nibble carries the next offset nibble (LSN first)
i_nibble  in  4  offset nibble
i_rtn  in  1  pop top of stack into PC
i_push_val  in  1  RSTK=C: push i_push_data
i_push_data  in  ADDR_W  value for i_push_val
i_pop_val  in  1  C=RSTK: pop to o_pop_data
o_pop_data  out  ADDR_W  popped value, valid in the cycle after i_pop_val
o_current_pc  out  ADDR_W  program counter
o_jump_busy  out  1  high in COLLECT and EXEC
o_jump_done  out  1  one-cycle pulse in the EXEC cycle
o_jump_err  out  1  one-cycle pulse on a rejected command
o_depth  out  PTR_W+1  valid entries, 0..RSTK_DEPTH
o_ovf  out  1  sticky: a push occurred while full
o_unf  out  1  sticky: a pop/rtn occurred while empty
i_dbg_ptr  in  PTR_W  debug entry index
o_dbg_val  out  ADDR_W  combinational read of entry i_dbg_ptr

Behaviour:
- Reset (synchronous, overrides everything): PC=0, state IDLE, all entries=0, ptr=RSTK_DEPTH-1, depth=0, ovf=unf=0, o_pop_data=0, busy/done/err=0.
- All actions below are qualified by i_clk_en. Done/err pulses are forced low while i_clk_en is low.
- FSM IDLE -> COLLECT -> EXEC -> IDLE.
- IDLE + i_jump_start:
  - If len is 0 or greater than MAX_JUMP_NIBS: pulse err, stay IDLE.
  - Otherwise latch len, rel and push; base <= PC; cnt=0; offset=0; go to COLLECT.
- COLLECT + i_nib_valid: offset[4*cnt +: 4] <= nibble; cnt++. On the len-th nibble, go to EXEC.
- EXEC, one cycle: done=1.
  - Target = rel ? base + sign_extend(offset, 4*len bits) : zero_extend(offset), truncated to ADDR_W (mod 2^ADDR_W).
  - If push latched: push the PC current in this cycle.
  - At cycle end PC <= target; return to IDLE.
- i_inc_pc applies in IDLE and COLLECT (offset fetch advances PC). In EXEC it is ignored (target wins).
- i_jump_start while busy: ignored, err pulse.
- i_rtn in IDLE: PC <= top; entry cleared to 0; ptr--; depth-- (floor 0). When empty, PC <= 0 and unf set. i_rtn overrides i_inc_pc.
- i_rtn while busy: ignored, err pulse.
- Push (EXEC push, or i_push_val):
  - ptr <= ptr+1 mod DEPTH; mem[ptr+1] <= value.
  - If depth == DEPTH: oldest entry overwritten, depth stays DEPTH, ovf set. Otherwise depth++.
- Pop (i_pop_val): o_pop_data <= top; entry cleared; ptr--; depth-- (floor 0). When empty, o_pop_data <= 0 and unf set.
- Same-cycle i_push_val + i_pop_val: pop happens first (o_pop_data = old top), then i_push_data is written at the same slot. Pointer and depth are unchanged.
- At most one stack-modifying source per cycle; priority EXEC-push > i_rtn > i_pop_val/i_push_val. A lower-priority request in the same cycle is dropped with an err pulse.
- Reset mid-jump or mid-stack-operation aborts it with no partial update.

Test Plan:
- Reset, then 3x i_inc_pc -> PC=0x00003, depth=0, all entries 0 via the debug port.
- PC=0x00100; jump rel len 3, nibbles 0xE,0xF,0xF (offset 0xFFE = -2), one i_inc_pc per nibble -> EXEC: target = 0x00100 - 2 = 0x000FE; done one cycle, PC=0x000FE.
- PC=0x12345; jump abs len 5, push, nibbles 0,0,0,8,0 -> PC=0x08000, depth=1, entry1 = PC at EXEC; i_rtn -> PC restored, depth=0, entry cleared.
- DEPTH=8: 9x i_push_val of values 1..9 -> depth=8, ovf=1, entries hold 2..9; 8 pops return 9..2; a 9th pop returns 0 and sets unf.
- Same-cycle push 0xAAAAA and pop with top 0x11111 -> o_pop_data=0x11111, top=0xAAAAA, depth unchanged.
- Jump len 0 -> err pulse, stays IDLE. Start a jump, feed 2 of 4 nibbles, assert i_reset -> IDLE, PC=0, no push.

Source files
------------

// File: rtl/saturn_rstk_jump_unit.sv
// saturn_rstk_jump_unit
// Program counter, jump-offset assembler and circular return stack for the
// Saturn core. Sits between the instruction decoder and the bus fetch unit.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_clk_en                global enable; state frozen while low
//   i_inc_pc                advance PC by one
//   i_jump_start/len/rel/push  start a jump (offset length, relative, GOSUB)
//   i_nib_valid, i_nibble   offset nibbles, least significant first
//   i_rtn                   pop top of stack into PC
//   i_push_val/i_push_data  RSTK=C push
//   i_pop_val, o_pop_data   C=RSTK pop, data valid the cycle after the request
//   o_current_pc            program counter (fetch address)
//   o_jump_busy/done/err    jump FSM status; done/err are one-cycle pulses
//   o_depth, o_ovf, o_unf   stack occupancy and sticky overflow/underflow
//   i_dbg_ptr, o_dbg_val    combinational debug read of any stack entry
module saturn_rstk_jump_unit #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned RSTK_DEPTH    = 8,
  parameter int unsigned MAX_JUMP_NIBS = 5,
  localparam int unsigned PTR_W        = $clog2(RSTK_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  input  logic              i_inc_pc,
  input  logic              i_jump_start,
  input  logic [2:0]        i_jump_len,
  input  logic              i_jump_rel,
  input  logic              i_jump_push,
  input  logic              i_nib_valid,
  input  logic [3:0]        i_nibble,
  input  logic              i_rtn,
  input  logic              i_push_val,
  input  logic [ADDR_W-1:0] i_push_data,
  input  logic              i_pop_val,
  output logic [ADDR_W-1:0] o_pop_data,
  output logic [ADDR_W-1:0] o_current_pc,
  output logic              o_jump_busy,
  output logic              o_jump_done,
  output logic              o_jump_err,
  output logic [PTR_W:0]    o_depth,
  output logic              o_ovf,
  output logic              o_unf,
  input  logic [PTR_W-1:0]  i_dbg_ptr,
  output logic [ADDR_W-1:0] o_dbg_val
);

  localparam int unsigned OFF_W      = 4 * MAX_JUMP_NIBS;
  localparam logic [2:0]  MAX_LEN    = 3'(MAX_JUMP_NIBS);
  localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(RSTK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EXEC    = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  offset;
  logic [2:0]        len;
  logic [2:0]        cnt;
  logic              rel;
  logic              push_l;
  logic [ADDR_W-1:0] mem [RSTK_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W:0]    depth;
  logic              ovf;
  logic              unf;
  logic [ADDR_W-1:0] pop_data;
  logic              err_q;

  // Control decode from the FSM and the command strobes.
  logic jump_accept, nib_take, err_c;
  logic do_exec_push, do_rtn, do_pop, do_push;

  // Stack operation decode.
  logic              empty, full, swap, pop_op, push_op, unf_set;
  logic [ADDR_W-1:0] push_value;
  logic [PTR_W-1:0]  ptr_inc, ptr_dec;

  // Jump target.
  logic              sign;
  logic [OFF_W-1:0]  ext;
  logic [ADDR_W-1:0] target;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else if (i_clk_en) begin
      state <= state_n;
    end
  end

  // Next state and arbitration between the PC and stack request sources.
  always_comb begin
    state_n      = state;
    jump_accept  = 1'b0;
    nib_take     = 1'b0;
    err_c        = 1'b0;
    do_exec_push = 1'b0;
    do_rtn       = 1'b0;
    do_pop       = 1'b0;
    do_push      = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_jump_start) begin
          if (i_jump_len == 3'd0 || i_jump_len > MAX_LEN) begin
            err_c = 1'b1;
          end else begin
            jump_accept = 1'b1;
            state_n     = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (i_jump_start) err_c = 1'b1;
        if (i_nib_valid) begin
          nib_take = 1'b1;
          if (cnt == len - 3'd1) state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_jump_start) err_c = 1'b1;
        do_exec_push = push_l;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A return competes with the PC load of a freshly accepted jump; the jump wins.
    if (i_rtn) begin
      if (state != S_IDLE || jump_accept) err_c = 1'b1;
      else                                do_rtn = 1'b1;
    end

    if (i_push_val || i_pop_val) begin
      if (do_exec_push || do_rtn) begin
        err_c = 1'b1;
      end else begin
        do_pop  = i_pop_val;
        do_push = i_push_val;
      end
    end
  end

  // Stack operation classification.
  always_comb begin
    empty      = (depth == '0);
    full       = (depth == DEPTH_FULL);
    // Combined push+pop on a non-empty stack replaces the top in place.
    swap       = do_pop & do_push & ~empty;
    pop_op     = (do_rtn | do_pop) & ~swap & ~empty;
    // On an empty stack a combined push+pop degrades to an underflowing pop
    // followed by an ordinary push.
    push_op    = (do_exec_push | do_push) & ~swap;
    unf_set    = (do_rtn | do_pop) & empty;
    push_value = do_exec_push ? pc : i_push_data;
    ptr_inc    = ptr + PTR_W'(1);
    ptr_dec    = ptr - PTR_W'(1);
  end

  // Offset sign extension from the latched length, then target formation.
  always_comb begin
    sign = 1'b0;
    ext  = '0;
    for (int n = 0; n < int'(MAX_JUMP_NIBS); n++) begin
      if (3'(n) == len - 3'd1) sign = offset[4*n+3];
    end
    for (int n = 0; n < int'(MAX_JUMP_NIBS); n++) begin
      if (3'(n) < len) ext[4*n +: 4] = offset[4*n +: 4];
      else             ext[4*n +: 4] = {4{sign}};
    end
    target = rel ? (base + ext[ADDR_W-1:0]) : ext[ADDR_W-1:0];
  end

  // PC, jump latches and offset assembly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc     <= '0;
      base   <= '0;
      offset <= '0;
      len    <= '0;
      cnt    <= '0;
      rel    <= 1'b0;
      push_l <= 1'b0;
    end else if (i_clk_en) begin
      if (state == S_EXEC) begin
        pc <= target;
      end else if (do_rtn) begin
        pc <= empty ? '0 : mem[ptr];
      end else if (i_inc_pc) begin
        pc <= pc + ADDR_W'(1);
      end

      if (jump_accept) begin
        len    <= i_jump_len;
        rel    <= i_jump_rel;
        push_l <= i_jump_push;
        base   <= pc;
        cnt    <= '0;
        offset <= '0;
      end

      if (nib_take) begin
        for (int n = 0; n < int'(MAX_JUMP_NIBS); n++) begin
          if (cnt == 3'(n)) offset[4*n +: 4] <= i_nibble;
        end
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Return stack storage, pointer, occupancy and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(RSTK_DEPTH); i++) mem[i] <= '0;
      ptr      <= PTR_W'(RSTK_DEPTH - 1);
      depth    <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      pop_data <= '0;
    end else if (i_clk_en) begin
      if (unf_set) begin
        unf <= 1'b1;
        if (do_pop) pop_data <= '0;
      end

      if (swap) begin
        pop_data <= mem[ptr];
        mem[ptr] <= i_push_data;
      end else if (pop_op) begin
        if (do_pop) pop_data <= mem[ptr];
        mem[ptr] <= '0;
        ptr      <= ptr_dec;
        depth    <= depth - (PTR_W+1)'(1);
      end else if (push_op) begin
        mem[ptr_inc] <= push_value;
        ptr          <= ptr_inc;
        if (full) ovf   <= 1'b1;
        else      depth <= depth + (PTR_W+1)'(1);
      end
    end
  end

  // Reject pulse, cleared whenever the enable is low.
  always_ff @(posedge i_clk) begin
    if (i_reset) err_q <= 1'b0;
    else         err_q <= i_clk_en & err_c;
  end

  assign o_current_pc = pc;
  assign o_pop_data   = pop_data;
  assign o_jump_busy  = (state != S_IDLE);
  assign o_jump_done  = (state == S_EXEC) & i_clk_en;
  assign o_jump_err   = err_q & i_clk_en;
  assign o_depth      = depth;
  assign o_ovf        = ovf;
  assign o_unf        = unf;
  assign o_dbg_val    = mem[i_dbg_ptr];

endmodule

// File: tb/tb_saturn_rstk_jump_unit.sv
// Directed testbench for saturn_rstk_jump_unit (default parameters).
module tb_saturn_rstk_jump_unit;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned PTR_W  = 3;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_clk_en;
  logic              i_inc_pc;
  logic              i_jump_start;
  logic [2:0]        i_jump_len;
  logic              i_jump_rel;
  logic              i_jump_push;
  logic              i_nib_valid;
  logic [3:0]        i_nibble;
  logic              i_rtn;
  logic              i_push_val;
  logic [ADDR_W-1:0] i_push_data;
  logic              i_pop_val;
  logic [ADDR_W-1:0] o_pop_data;
  logic [ADDR_W-1:0] o_current_pc;
  logic              o_jump_busy;
  logic              o_jump_done;
  logic              o_jump_err;
  logic [PTR_W:0]    o_depth;
  logic              o_ovf;
  logic              o_unf;
  logic [PTR_W-1:0]  i_dbg_ptr;
  logic [ADDR_W-1:0] o_dbg_val;

  int checks = 0;
  int errors = 0;

  saturn_rstk_jump_unit dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clk_en     (i_clk_en),
    .i_inc_pc     (i_inc_pc),
    .i_jump_start (i_jump_start),
    .i_jump_len   (i_jump_len),
    .i_jump_rel   (i_jump_rel),
    .i_jump_push  (i_jump_push),
    .i_nib_valid  (i_nib_valid),
    .i_nibble     (i_nibble),
    .i_rtn        (i_rtn),
    .i_push_val   (i_push_val),
    .i_push_data  (i_push_data),
    .i_pop_val    (i_pop_val),
    .o_pop_data   (o_pop_data),
    .o_current_pc (o_current_pc),
    .o_jump_busy  (o_jump_busy),
    .o_jump_done  (o_jump_done),
    .o_jump_err   (o_jump_err),
    .o_depth      (o_depth),
    .o_ovf        (o_ovf),
    .o_unf        (o_unf),
    .i_dbg_ptr    (i_dbg_ptr),
    .o_dbg_val    (o_dbg_val)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_reset      = 1'b0;
    i_clk_en     = 1'b1;
    i_inc_pc     = 1'b0;
    i_jump_start = 1'b0;
    i_jump_len   = 3'd0;
    i_jump_rel   = 1'b0;
    i_jump_push  = 1'b0;
    i_nib_valid  = 1'b0;
    i_nibble     = 4'h0;
    i_rtn        = 1'b0;
    i_push_val   = 1'b0;
    i_push_data  = '0;
    i_pop_val    = 1'b0;
    i_dbg_ptr    = '0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  // Load PC with an arbitrary value by pushing it and returning to it.
  task automatic load_pc(input logic [ADDR_W-1:0] v);
    i_push_val  = 1'b1;
    i_push_data = v;
    tick();
    i_push_val  = 1'b0;
    i_rtn       = 1'b1;
    tick();
    i_rtn       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    checks++; if (o_current_pc !== 20'h00000) begin errors++; $display("FAIL reset_pc got %h exp %h", o_current_pc, 20'h00000); end
    checks++; if (o_depth !== 4'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", o_depth); end
    checks++; if ({o_jump_busy, o_jump_done, o_jump_err, o_ovf, o_unf} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {o_jump_busy, o_jump_done, o_jump_err, o_ovf, o_unf}); end
    i_inc_pc = 1'b1;
    repeat (3) tick();
    i_inc_pc = 1'b0;
    checks++; if (o_current_pc !== 20'h00003) begin errors++; $display("FAIL inc_pc got %h exp %h", o_current_pc, 20'h00003); end
    for (int i = 0; i < 8; i++) begin
      i_dbg_ptr = 3'(i);
      tick();
      checks++; if (o_dbg_val !== 20'h0) begin errors++; $display("FAIL reset_entry%0d got %h exp 0", i, o_dbg_val); end
    end
  endtask

  task automatic test_rel_jump();
    logic [3:0] nibs [3];
    nibs = '{4'hE, 4'hF, 4'hF};
    clear_inputs();
    do_reset();
    load_pc(20'h00100);
    checks++; if (o_current_pc !== 20'h00100) begin errors++; $display("FAIL rel_load_pc got %h exp %h", o_current_pc, 20'h00100); end
    i_jump_start = 1'b1; i_jump_len = 3'd3; i_jump_rel = 1'b1;
    tick();
    i_jump_start = 1'b0;
    checks++; if (o_jump_busy !== 1'b1) begin errors++; $display("FAIL rel_busy got %b exp 1", o_jump_busy); end
    for (int i = 0; i < 3; i++) begin
      i_nib_valid = 1'b1; i_nibble = nibs[i]; i_inc_pc = 1'b1;
      tick();
    end
    i_nib_valid = 1'b0;
    checks++; if (o_jump_done !== 1'b1) begin errors++; $display("FAIL rel_done got %b exp 1", o_jump_done); end
    checks++; if (o_current_pc !== 20'h00103) begin errors++; $display("FAIL rel_fetch_pc got %h exp %h", o_current_pc, 20'h00103); end
    tick();
    i_inc_pc = 1'b0;
    checks++; if (o_current_pc !== 20'h000FE) begin errors++; $display("FAIL rel_target got %h exp %h", o_current_pc, 20'h000FE); end
    checks++; if ({o_jump_done, o_jump_busy} !== 2'b00) begin errors++; $display("FAIL rel_after got %b exp 00", {o_jump_done, o_jump_busy}); end
  endtask

  task automatic test_abs_push();
    logic [3:0] nibs [5];
    nibs = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
    clear_inputs();
    do_reset();
    load_pc(20'h12345);
    i_jump_start = 1'b1; i_jump_len = 3'd5; i_jump_rel = 1'b0; i_jump_push = 1'b1;
    tick();
    i_jump_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_nib_valid = 1'b1; i_nibble = nibs[i];
      tick();
    end
    i_nib_valid = 1'b0;
    checks++; if (o_jump_done !== 1'b1) begin errors++; $display("FAIL abs_done got %b exp 1", o_jump_done); end
    tick();
    checks++; if (o_current_pc !== 20'h08000) begin errors++; $display("FAIL abs_target got %h exp %h", o_current_pc, 20'h08000); end
    checks++; if (o_depth !== 4'd1) begin errors++; $display("FAIL abs_depth got %0d exp 1", o_depth); end
    i_dbg_ptr = 3'd0;
    tick();
    checks++; if (o_dbg_val !== 20'h12345) begin errors++; $display("FAIL abs_pushed got %h exp %h", o_dbg_val, 20'h12345); end
    i_rtn = 1'b1;
    tick();
    i_rtn = 1'b0;
    checks++; if (o_current_pc !== 20'h12345) begin errors++; $display("FAIL rtn_pc got %h exp %h", o_current_pc, 20'h12345); end
    checks++; if (o_depth !== 4'd0) begin errors++; $display("FAIL rtn_depth got %0d exp 0", o_depth); end
    checks++; if (o_dbg_val !== 20'h0) begin errors++; $display("FAIL rtn_cleared got %h exp 0", o_dbg_val); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] exp_v;
    clear_inputs();
    do_reset();
    for (int v = 1; v <= 9; v++) begin
      i_push_val = 1'b1; i_push_data = 20'(v);
      tick();
    end
    i_push_val = 1'b0;
    checks++; if (o_depth !== 4'd8) begin errors++; $display("FAIL ovf_depth got %0d exp 8", o_depth); end
    checks++; if ({o_ovf, o_unf} !== 2'b10) begin errors++; $display("FAIL ovf_flags got %b exp 10", {o_ovf, o_unf}); end
    // Slot 0 was overwritten by the ninth push; slots 1..7 hold 2..8.
    for (int i = 0; i < 8; i++) begin
      i_dbg_ptr = 3'(i);
      tick();
      exp_v = (i == 0) ? 20'd9 : 20'(i + 1);
      checks++; if (o_dbg_val !== exp_v) begin errors++; $display("FAIL ovf_entry%0d got %h exp %h", i, o_dbg_val, exp_v); end
    end
    i_pop_val = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_v = 20'(9 - k);
      checks++; if (o_pop_data !== exp_v) begin errors++; $display("FAIL pop%0d got %h exp %h", k, o_pop_data, exp_v); end
    end
    tick();
    i_pop_val = 1'b0;
    checks++; if (o_pop_data !== 20'h0) begin errors++; $display("FAIL unf_data got %h exp 0", o_pop_data); end
    checks++; if (o_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", o_unf); end
    checks++; if (o_depth !== 4'd0) begin errors++; $display("FAIL unf_depth got %0d exp 0", o_depth); end
  endtask

  task automatic test_swap();
    clear_inputs();
    do_reset();
    i_push_val = 1'b1; i_push_data = 20'h11111;
    tick();
    i_push_data = 20'hAAAAA; i_pop_val = 1'b1;
    tick();
    i_push_val = 1'b0; i_pop_val = 1'b0;
    i_dbg_ptr = 3'd0;
    tick();
    checks++; if (o_pop_data !== 20'h11111) begin errors++; $display("FAIL swap_pop got %h exp %h", o_pop_data, 20'h11111); end
    checks++; if (o_dbg_val !== 20'hAAAAA) begin errors++; $display("FAIL swap_top got %h exp %h", o_dbg_val, 20'hAAAAA); end
    checks++; if (o_depth !== 4'd1) begin errors++; $display("FAIL swap_depth got %0d exp 1", o_depth); end
  endtask

  task automatic test_errors();
    clear_inputs();
    do_reset();
    i_jump_start = 1'b1; i_jump_len = 3'd0;
    tick();
    i_jump_start = 1'b0;
    checks++; if ({o_jump_err, o_jump_busy} !== 2'b10) begin errors++; $display("FAIL len0 got %b exp 10", {o_jump_err, o_jump_busy}); end
    tick();
    checks++; if (o_jump_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", o_jump_err); end
    i_jump_start = 1'b1; i_jump_len = 3'd6;
    tick();
    i_jump_start = 1'b0;
    checks++; if ({o_jump_err, o_jump_busy} !== 2'b10) begin errors++; $display("FAIL len6 got %b exp 10", {o_jump_err, o_jump_busy}); end
    // Return takes priority over a same-cycle RSTK=C push.
    i_push_val = 1'b1; i_push_data = 20'h00555;
    tick();
    i_push_data = 20'h00777; i_rtn = 1'b1;
    tick();
    i_push_val = 1'b0; i_rtn = 1'b0;
    checks++; if (o_current_pc !== 20'h00555) begin errors++; $display("FAIL prio_pc got %h exp %h", o_current_pc, 20'h00555); end
    checks++; if ({o_jump_err, o_depth} !== {1'b1, 4'd0}) begin errors++; $display("FAIL prio_err_depth got %b/%0d exp 1/0", o_jump_err, o_depth); end
    i_jump_start = 1'b1; i_jump_len = 3'd2;
    tick();
    i_jump_len = 3'd1;
    tick();
    i_jump_start = 1'b0;
    checks++; if ({o_jump_err, o_jump_busy} !== 2'b11) begin errors++; $display("FAIL busy_start got %b exp 11", {o_jump_err, o_jump_busy}); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    do_reset();
    i_inc_pc = 1'b1;
    repeat (2) tick();
    i_inc_pc = 1'b0;
    i_jump_start = 1'b1; i_jump_len = 3'd4; i_jump_push = 1'b1;
    tick();
    i_jump_start = 1'b0;
    i_nib_valid = 1'b1; i_nibble = 4'h7;
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++; if ({o_jump_busy, o_current_pc} !== {1'b0, 20'h0}) begin errors++; $display("FAIL midreset got %b/%h exp 0/00000", o_jump_busy, o_current_pc); end
    repeat (2) tick();
    i_nib_valid = 1'b0;
    checks++; if ({o_jump_busy, o_jump_done, o_depth, o_current_pc} !== {2'b00, 4'd0, 20'h0}) begin errors++; $display("FAIL midreset_after got %b%b/%0d/%h exp 00/0/00000", o_jump_busy, o_jump_done, o_depth, o_current_pc); end
  endtask

  task automatic test_clk_en();
    clear_inputs();
    do_reset();
    i_clk_en = 1'b0;
    i_inc_pc = 1'b1;
    i_jump_start = 1'b1; i_jump_len = 3'd0;
    repeat (2) tick();
    checks++; if ({o_current_pc, o_jump_err} !== {20'h0, 1'b0}) begin errors++; $display("FAIL clk_en_hold got %h/%b exp 00000/0", o_current_pc, o_jump_err); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_rel_jump();
    test_abs_push();
    test_overflow();
    test_swap();
    test_errors();
    test_reset_mid();
    test_clk_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
